// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner: sequential fetch, redirects, stall, halt-word drain
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [25:0] jump_target,
    input  logic [31:0] fetched_instn,
    output logic [31:0] fetch_pc,
    output logic [31:0] ifid_instn,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] cycle_count,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    localparam int            CW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    state_t        r_state;
    logic [CW-1:0] r_drain_cnt;

    logic [31:0] w_branch_pc;
    logic [31:0] w_jump_pc;
    logic        w_branch_mis;
    logic        w_jump_mis;

    assign w_branch_pc  = {branch_target[31:2], 2'b00};
    assign w_jump_pc    = {6'b0, jump_target[25:2], 2'b00};
    assign w_branch_mis = |branch_target[1:0];
    assign w_jump_mis   = |jump_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_drain_cnt    <= '0;
            fetch_pc       <= RESET_PC;
            ifid_instn     <= '0;
            ifid_pc        <= '0;
            ifid_valid     <= 1'b0;
            halted         <= 1'b0;
            misalign_err   <= 1'b0;
            cycle_count    <= '0;
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (branch_taken) begin
                        fetch_pc       <= w_branch_pc;
                        ifid_valid     <= 1'b0;
                        redirect_count <= redirect_count + 32'd1;
                        if (w_branch_mis) misalign_err <= 1'b1;
                    end else if (stall) begin
                        // frozen: only cycle_count advances
                    end else if (jump_valid) begin
                        fetch_pc       <= w_jump_pc;
                        ifid_valid     <= 1'b0;
                        redirect_count <= redirect_count + 32'd1;
                        if (w_jump_mis) misalign_err <= 1'b1;
                    end else if (fetched_instn == HALT_WORD) begin
                        ifid_valid  <= 1'b0;
                        r_drain_cnt <= DRAIN_LOAD;
                        r_state     <= S_DRAIN;
                    end else begin
                        ifid_instn  <= fetched_instn;
                        ifid_pc     <= fetch_pc;
                        ifid_valid  <= 1'b1;
                        fetch_pc    <= fetch_pc + 32'd4;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                S_DRAIN: begin
                    cycle_count <= cycle_count + 32'd1;
                    ifid_valid  <= 1'b0;
                    // an older branch resolving now cancels the halt
                    if (branch_taken) begin
                        fetch_pc       <= w_branch_pc;
                        redirect_count <= redirect_count + 32'd1;
                        if (w_branch_mis) misalign_err <= 1'b1;
                        r_drain_cnt    <= '0;
                        r_state        <= S_RUN;
                    end else if (r_drain_cnt == '0) begin
                        halted  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - CW'(1);
                    end
                end
                S_HALT: begin
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - table-driven and directed checks for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [25:0] jump_target;
    logic [31:0] fetched_instn;
    logic [31:0] fetch_pc;
    logic [31:0] ifid_instn;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] cycle_count;
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] HW = 32'hFFFF_FFFF;
    localparam logic [31:0] IA = 32'h1111_0001;
    localparam logic [31:0] IB = 32'h2222_0002;
    localparam logic [31:0] IC = 32'h3333_0003;
    localparam logic [31:0] ID = 32'h4444_0004;
    localparam logic [31:0] IE = 32'h5555_0005;
    localparam logic [31:0] IF = 32'h6666_0006;
    localparam logic [31:0] IG = 32'h7777_0007;
    localparam logic [31:0] IH = 32'h8888_0008;
    localparam logic [31:0] II = 32'h9999_0009;
    localparam logic [31:0] IJ = 32'hAAAA_000A;
    localparam logic [31:0] IK = 32'hBBBB_000B;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .fetched_instn  (fetched_instn),
        .fetch_pc       (fetch_pc),
        .ifid_instn     (ifid_instn),
        .ifid_pc        (ifid_pc),
        .ifid_valid     (ifid_valid),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .cycle_count    (cycle_count),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        bt;
        logic [31:0] btgt;
        logic        jv;
        logic [25:0] jt;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] iin;
        logic [31:0] ipc;
        logic        iv;
        logic        hl;
        logic        mis;
        logic [31:0] cc;
        logic [31:0] fc;
        logic [31:0] rc;
    } vec_t;

    function automatic vec_t mk(logic st, logic bt, logic [31:0] btgt, logic jv, logic [25:0] jt,
                                logic [31:0] ins, logic [31:0] pc, logic [31:0] iin, logic [31:0] ipc,
                                logic iv, logic hl, logic mis, logic [31:0] cc, logic [31:0] fc,
                                logic [31:0] rc);
        vec_t v;
        v.st = st; v.bt = bt; v.btgt = btgt; v.jv = jv; v.jt = jt; v.ins = ins;
        v.pc = pc; v.iin = iin; v.ipc = ipc; v.iv = iv; v.hl = hl; v.mis = mis;
        v.cc = cc; v.fc = fc; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string lbl, input vec_t v);
        chk({lbl, ".fetch_pc"},       fetch_pc,              v.pc);
        chk({lbl, ".ifid_instn"},     ifid_instn,            v.iin);
        chk({lbl, ".ifid_pc"},        ifid_pc,               v.ipc);
        chk({lbl, ".ifid_valid"},     {31'd0, ifid_valid},   {31'd0, v.iv});
        chk({lbl, ".halted"},         {31'd0, halted},       {31'd0, v.hl});
        chk({lbl, ".misalign_err"},   {31'd0, misalign_err}, {31'd0, v.mis});
        chk({lbl, ".cycle_count"},    cycle_count,           v.cc);
        chk({lbl, ".fetch_count"},    fetch_count,           v.fc);
        chk({lbl, ".redirect_count"}, redirect_count,        v.rc);
    endtask

    task automatic apply(input string lbl, input vec_t v);
        stall         = v.st;
        branch_taken  = v.bt;
        branch_target = v.btgt;
        jump_valid    = v.jv;
        jump_target   = v.jt;
        fetched_instn = v.ins;
        @(posedge clk);
        #1;
        check_outputs(lbl, v);
    endtask

    task automatic do_reset(input string lbl);
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0042;
        jump_valid    = 1'b1;
        jump_target   = 26'h101;
        fetched_instn = HW;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs(lbl, mk(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(0, 0, 0,        0, 0,       IA, 32'h04,  IA, 32'h00,  1, 0, 0, 1,  1, 0);
        tbl[1]  = mk(0, 0, 0,        0, 0,       IB, 32'h08,  IB, 32'h04,  1, 0, 0, 2,  2, 0);
        tbl[2]  = mk(0, 0, 0,        0, 0,       IC, 32'h0C,  IC, 32'h08,  1, 0, 0, 3,  3, 0);
        tbl[3]  = mk(0, 0, 0,        0, 0,       ID, 32'h10,  ID, 32'h0C,  1, 0, 0, 4,  4, 0);
        tbl[4]  = mk(1, 1, 32'h40,   1, 26'h200, IE, 32'h40,  ID, 32'h0C,  0, 0, 0, 5,  4, 1);
        tbl[5]  = mk(0, 0, 0,        0, 0,       IE, 32'h44,  IE, 32'h40,  1, 0, 0, 6,  5, 1);
        tbl[6]  = mk(0, 0, 0,        0, 0,       IF, 32'h48,  IF, 32'h44,  1, 0, 0, 7,  6, 1);
        tbl[7]  = mk(1, 0, 0,        0, 0,       IG, 32'h48,  IF, 32'h44,  1, 0, 0, 8,  6, 1);
        tbl[8]  = mk(1, 0, 0,        0, 0,       IG, 32'h48,  IF, 32'h44,  1, 0, 0, 9,  6, 1);
        tbl[9]  = mk(1, 0, 0,        0, 0,       IG, 32'h48,  IF, 32'h44,  1, 0, 0, 10, 6, 1);
        tbl[10] = mk(0, 0, 0,        0, 0,       IG, 32'h4C,  IG, 32'h48,  1, 0, 0, 11, 7, 1);
        tbl[11] = mk(0, 0, 0,        1, 26'h100, IH, 32'h100, IG, 32'h48,  0, 0, 0, 12, 7, 2);
        tbl[12] = mk(0, 0, 0,        0, 0,       II, 32'h104, II, 32'h100, 1, 0, 0, 13, 8, 2);
        tbl[13] = mk(1, 0, 0,        1, 26'h200, IJ, 32'h104, II, 32'h100, 1, 0, 0, 14, 8, 2);

        do_reset("rst0");
        for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // halt word enters a 4-cycle drain; stall/jump ignored there
        apply("halt_word", mk(0, 0, 0, 0, 0, HW, 32'h104, II, 32'h100, 0, 0, 0, 15, 8, 2));
        for (int i = 0; i < 3; i++)
            apply($sformatf("drain%0d", i + 1),
                  mk(1, 0, 0, 1, 26'h300, IK, 32'h104, II, 32'h100, 0, 0, 0, 16 + i, 8, 2));
        apply("drain_last", mk(0, 0, 0, 0, 0, IK, 32'h104, II, 32'h100, 0, 1, 0, 19, 8, 2));
        for (int i = 0; i < 3; i++)
            apply($sformatf("halt%0d", i),
                  mk(0, 1, 32'h80, 0, 0, IA, 32'h104, II, 32'h100, 0, 1, 0, 19, 8, 2));

        // reset out of HALT, then a branch cancels a drain in its second cycle
        do_reset("rst_halt");
        apply("r1_fetch",  mk(0, 0, 0,      0, 0, IA, 32'h04, IA, 32'h00, 1, 0, 0, 1, 1, 0));
        apply("r1_halt",   mk(0, 0, 0,      0, 0, HW, 32'h04, IA, 32'h00, 0, 0, 0, 2, 1, 0));
        apply("r1_drain1", mk(0, 0, 0,      0, 0, IK, 32'h04, IA, 32'h00, 0, 0, 0, 3, 1, 0));
        apply("r1_dbr",    mk(0, 1, 32'h42, 0, 0, IK, 32'h40, IA, 32'h00, 0, 0, 1, 4, 1, 1));
        apply("r1_run",    mk(0, 0, 0,      0, 0, IB, 32'h44, IB, 32'h40, 1, 0, 1, 5, 2, 1));
        apply("r1_halt2",  mk(0, 0, 0,      0, 0, HW, 32'h44, IB, 32'h40, 0, 0, 1, 6, 2, 1));
        apply("r1_drain2", mk(0, 0, 0,      0, 0, IK, 32'h44, IB, 32'h40, 0, 0, 1, 7, 2, 1));

        // reset mid-drain, then misaligned jump and PC wrap
        do_reset("rst_drain");
        apply("r2_fetch", mk(0, 0, 0,            0, 0,       IA, 32'h04,        IA, 32'h00,        1, 0, 0, 1, 1, 0));
        apply("r2_jmis",  mk(0, 0, 0,            1, 26'h101, IB, 32'h100,       IA, 32'h00,        0, 0, 1, 2, 1, 1));
        apply("r2_bwrap", mk(0, 1, 32'hFFFFFFFF, 0, 0,       IB, 32'hFFFFFFFC,  IA, 32'h00,        0, 0, 1, 3, 1, 2));
        apply("r2_wrap",  mk(0, 0, 0,            0, 0,       IC, 32'h00,        IC, 32'hFFFFFFFC,  1, 0, 1, 4, 2, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
